// File: rtl/osc_step_sequencer_pkg.sv
// osc_step_sequencer_pkg: shared FSM states, default widths and step record
package osc_step_sequencer_pkg;
    localparam int PHASESIZE_DEF = 16;
    localparam int DURSIZE_DEF   = 16;
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;
    typedef struct packed {
        logic [PHASESIZE_DEF-1:0] freq;
        logic [DURSIZE_DEF-1:0]   dur;
    } step_t;
endpackage

// File: rtl/seq_step_ram.sv
// seq_step_ram: step table with one write port and two asynchronous read ports
module seq_step_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_ra_addr,
    output logic [WIDTH-1:0]         o_ra_data,
    input  logic [$clog2(DEPTH)-1:0] i_rb_addr,
    output logic [WIDTH-1:0]         o_rb_data
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    // table contents survive reset; only the write strobe changes them
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end
    assign o_ra_data = r_mem[i_ra_addr];
    assign o_rb_data = r_mem[i_rb_addr];
endmodule

// File: rtl/osc_step_sequencer.sv
// osc_step_sequencer: plays a table of freq/duration steps into one oscillator
module osc_step_sequencer
    import osc_step_sequencer_pkg::*;
#(
    parameter int PHASESIZE = PHASESIZE_DEF,
    parameter int DURSIZE   = DURSIZE_DEF,
    parameter int STEPS     = 8,
    parameter int GAP       = 64
) (
    input  logic                     lrclk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    input  logic                     wr_en,
    input  logic [$clog2(STEPS)-1:0] wr_addr,
    input  logic [PHASESIZE-1:0]     wr_freq,
    input  logic [DURSIZE-1:0]       wr_dur,
    output logic [PHASESIZE-1:0]     freq,
    output logic                     enable,
    output logic [$clog2(STEPS)-1:0] step,
    output logic                     busy,
    output logic                     done
);
    localparam int AW = $clog2(STEPS);
    localparam int DW = PHASESIZE + DURSIZE;
    localparam bit HAS_GAP = GAP > 0;
    localparam logic [DURSIZE-1:0] GAP_LAST = DURSIZE'(GAP - 1);

    state_t               r_state, w_state;
    logic [AW-1:0]        r_step, w_step, w_next;
    logic [PHASESIZE-1:0] r_freq, w_freq, w_a_freq, w_b_freq;
    logic [DURSIZE-1:0]   r_dur, w_dur, r_cnt, w_cnt, w_a_dur, w_b_dur;
    logic                 r_enable, w_enable, r_busy, w_busy, r_done, w_done;
    logic                 w_go, w_to0, w_idle, w_end, w_wrap, w_play_end;
    logic [DW-1:0]        w_a_data, w_b_data;

    // port A looks at the following step, port B always at step 0
    seq_step_ram #(.DEPTH(STEPS), .WIDTH(DW)) u_ram (
        .clk       (lrclk),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data ({wr_freq, wr_dur}),
        .i_ra_addr (w_next),
        .o_ra_data (w_a_data),
        .i_rb_addr ('0),
        .o_rb_data (w_b_data)
    );

    assign w_next     = r_step + 1'b1;
    assign w_a_freq   = w_a_data[DW-1:DURSIZE];
    assign w_a_dur    = w_a_data[DURSIZE-1:0];
    assign w_b_freq   = w_b_data[DW-1:DURSIZE];
    assign w_b_dur    = w_b_data[DURSIZE-1:0];
    assign w_end      = r_step == AW'(STEPS - 1) || w_a_dur == '0;
    assign w_wrap     = loop && w_b_dur != '0;
    assign w_play_end = r_state == S_PLAY && r_cnt == r_dur - 1'b1;

    // next-state and next-output decode; stop overrides every transition
    always_comb begin
        w_state  = r_state;
        w_step   = r_step;
        w_freq   = r_freq;
        w_dur    = r_dur;
        w_cnt    = r_cnt + 1'b1;
        w_enable = r_enable;
        w_busy   = r_busy;
        w_done   = 1'b0;
        w_go     = 1'b0;
        w_to0    = 1'b0;
        w_idle   = 1'b0;
        if (r_state == S_IDLE) begin
            w_cnt  = '0;
            w_go   = start && w_b_dur != '0;
            w_to0  = 1'b1;
            w_done = start && w_b_dur == '0;
        end else if (w_play_end && HAS_GAP) begin
            w_state  = S_GAP;
            w_enable = 1'b0;
            w_cnt    = '0;
        end else if (w_play_end || (r_state == S_GAP && r_cnt == GAP_LAST)) begin
            w_go   = !w_end || w_wrap;
            w_to0  = w_end;
            w_idle = w_end && !w_wrap;
            w_done = w_end && !w_wrap;
        end
        if (w_go) begin
            w_state  = S_PLAY;
            w_step   = w_to0 ? '0 : w_next;
            w_freq   = w_to0 ? w_b_freq : w_a_freq;
            w_dur    = w_to0 ? w_b_dur : w_a_dur;
            w_cnt    = '0;
            w_enable = 1'b1;
            w_busy   = 1'b1;
        end
        if (w_idle || stop) begin
            w_state  = S_IDLE;
            w_step   = '0;
            w_freq   = '0;
            w_cnt    = '0;
            w_enable = 1'b0;
            w_busy   = 1'b0;
            w_done   = w_done && !stop;
        end
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge lrclk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_step   <= '0;
            r_freq   <= '0;
            r_dur    <= '0;
            r_cnt    <= '0;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_step   <= w_step;
            r_freq   <= w_freq;
            r_dur    <= w_dur;
            r_cnt    <= w_cnt;
            r_enable <= w_enable;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    assign freq   = r_freq;
    assign enable = r_enable;
    assign step   = r_step;
    assign busy   = r_busy;
    assign done   = r_done;
endmodule
